// File: rtl/mult_test_sequencer_pkg.sv
// Shared types and constants for the multiplier test sequencer.
package mult_test_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } seq_state_e;

  localparam int unsigned LATENCY_MAX = 64;
  // Drain countdown holds LATENCY-1, so LATENCY_MAX-1 must fit.
  localparam int unsigned DRAIN_W = $clog2(LATENCY_MAX);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mult_test_sequencer_if.sv
// RAM-side port of the sequencer: operand read address and result write strobe/address.
interface mult_test_sequencer_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  we;
  logic [ADDR_WIDTH-1:0] w_addr;

  modport master (output r_en, r_addr, we, w_addr);
  modport slave  (input  r_en, r_addr, we, w_addr);
endinterface

// File: rtl/mult_test_sequencer_seq_addr_pipe.sv
// Fixed-depth {valid, addr} delay line; only the valid bits are reset so a
// reset drops every pending write.
module seq_addr_pipe #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr
);

  (* altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
  logic [DEPTH-1:0]      valid_q;
  (* altera_attribute = "-name AUTO_SHIFT_REGISTER_RECOGNITION OFF" *)
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q[0] <= in_addr;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      addr_q[i] <= addr_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  // Address flops are unreset; mask them so w_addr reads 0 whenever no write is pending.
  assign out_addr  = out_valid ? addr_q[DEPTH-1] : '0;

endmodule

// File: rtl/mult_test_sequencer.sv
// Issues a (possibly repeated) contiguous operand read range and the matching
// result writes LATENCY cycles later, with run status and cycle count.
module mult_test_sequencer
  import mult_test_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned ITER_WIDTH = 16
) (
  input  logic                  pll_clock,
  input  logic                  resetn,
  input  logic                  pll_lock,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] first_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic [ITER_WIDTH-1:0] iterations,
  mult_test_sequencer_if.master ram,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  cfg_err,
  output logic [31:0]           cycle_count
);

  seq_state_e            state_q;
  logic                  r_en_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [ADDR_WIDTH-1:0] first_q;
  logic [ADDR_WIDTH-1:0] last_q;
  logic [ITER_WIDTH-1:0] passes_q;
  logic [DRAIN_W-1:0]    drain_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  aborted_q;
  logic                  cfg_err_q;
  logic [31:0]           cycle_q;
  logic                  stop_req;

  assign stop_req = abort || !pll_lock;

  always_ff @(posedge pll_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      r_en_q    <= 1'b0;
      r_addr_q  <= '0;
      first_q   <= '0;
      last_q    <= '0;
      passes_q  <= '0;
      drain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
      cycle_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start && pll_lock) begin
            first_q   <= first_addr;
            last_q    <= last_addr;
            passes_q  <= (iterations == '0) ? ITER_WIDTH'(1) : iterations;
            aborted_q <= 1'b0;
            cycle_q   <= '0;
            if (last_addr < first_addr) begin
              cfg_err_q <= 1'b1;
              done_q    <= 1'b1;
              state_q   <= StDone;
            end else begin
              cfg_err_q <= 1'b0;
              done_q    <= 1'b0;
              busy_q    <= 1'b1;
              r_en_q    <= 1'b1;
              r_addr_q  <= first_addr;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          cycle_q <= sat_inc(cycle_q);
          if (stop_req) begin
            aborted_q <= 1'b1;
            r_en_q    <= 1'b0;
            drain_q   <= DRAIN_W'(LATENCY - 1);
            state_q   <= StDrain;
          end else if (r_addr_q == last_q) begin
            // Wrap to the range start with no bubble while passes remain.
            if (passes_q > ITER_WIDTH'(1)) begin
              passes_q <= passes_q - ITER_WIDTH'(1);
              r_addr_q <= first_q;
            end else begin
              r_en_q  <= 1'b0;
              drain_q <= DRAIN_W'(LATENCY - 1);
              state_q <= StDrain;
            end
          end else begin
            r_addr_q <= r_addr_q + ADDR_WIDTH'(1);
          end
        end
        StDrain: begin
          cycle_q <= sat_inc(cycle_q);
          if (stop_req) begin
            aborted_q <= 1'b1;
          end
          if (drain_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            drain_q <= drain_q - DRAIN_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  seq_addr_pipe #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (LATENCY)
  ) u_addr_pipe (
    .clk       (pll_clock),
    .rst_n     (resetn),
    .in_valid  (r_en_q),
    .in_addr   (r_addr_q),
    .out_valid (ram.we),
    .out_addr  (ram.w_addr)
  );

  assign ram.r_en     = r_en_q;
  assign ram.r_addr   = r_addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign cfg_err      = cfg_err_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_mult_test_sequencer.sv
// Directed scoreboard bench for mult_test_sequencer (ADDR_WIDTH=8, LATENCY=4).
module tb_mult_test_sequencer;

  localparam int LAT = 4;

  logic        clk;
  logic        resetn;
  logic        pll_lock;
  logic        start;
  logic        abort;
  logic [7:0]  first_addr;
  logic [7:0]  last_addr;
  logic [15:0] iterations;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [31:0] cycle_count;

  mult_test_sequencer_if #(.ADDR_WIDTH(8)) ram ();

  mult_test_sequencer #(
    .ADDR_WIDTH (8),
    .LATENCY    (LAT),
    .ITER_WIDTH (16)
  ) dut (
    .pll_clock   (clk),
    .resetn      (resetn),
    .pll_lock    (pll_lock),
    .start       (start),
    .abort       (abort),
    .first_addr  (first_addr),
    .last_addr   (last_addr),
    .iterations  (iterations),
    .ram         (ram),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .cfg_err     (cfg_err),
    .cycle_count (cycle_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_seen  = 0;
  int wr_seen  = 0;
  int last_rd_cyc = 0;
  int last_we_cyc = 0;
  logic [7:0] exp_rd [$];
  logic [7:0] exp_wr [$];
  int         rd_cyc [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // RAM-port monitor: reads must match the model in order with no gaps, and
  // each write must follow its read by exactly LAT cycles.
  always @(negedge clk) begin
    if (resetn) begin
      if (ram.r_en) begin
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) chk("r_addr", 32'(ram.r_addr), 32'(exp_rd.pop_front()));
        if (rd_seen > 0) chk("read_gap", cyc - last_rd_cyc, 1);
        rd_seen++;
        last_rd_cyc = cyc;
        rd_cyc.push_back(cyc);
      end
      if (ram.we) begin
        chk("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) chk("w_addr", 32'(ram.w_addr), 32'(exp_wr.pop_front()));
        if (rd_cyc.size() != 0) chk("wr_latency", cyc - rd_cyc.pop_front(), LAT);
        wr_seen++;
        last_we_cyc = cyc;
      end
    end
  end

  task automatic run_case(input logic [7:0] f, input logic [7:0] l, input logic [15:0] it,
                          input int kill_at, input bit by_lock);
    int r, p, n, w;
    bit cfg, killed;
    logic [7:0] a;
    cfg    = (l < f);
    r      = int'(l) - int'(f) + 1;
    p      = (it == 0) ? 1 : int'(it);
    n      = cfg ? 0 : p * r;
    killed = (kill_at > 0) && (kill_at <= n);
    if (killed) n = kill_at;
    for (int k = 0; k < n; k++) begin
      a = f + 8'(k % r);
      exp_rd.push_back(a);
      exp_wr.push_back(a);
    end
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk);
    first_addr = f; last_addr = l; iterations = it; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (cfg) begin
      chk("cfg_done_next", 32'(done), 1);
      chk("cfg_busy", 32'(busy), 0);
    end else begin
      chk("first_ren", 32'(ram.r_en), 1);
      chk("first_busy", 32'(busy), 1);
    end
    if (killed) begin
      repeat (kill_at - 1) @(negedge clk);
      if (by_lock) pll_lock = 1'b0;
      else abort = 1'b1;
      @(negedge clk);
      pll_lock = 1'b1;
      abort    = 1'b0;
    end
    w = 0;
    while (!done && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", 32'(done), 1);
    if (!cfg) chk("done_after_last_we", cyc - last_we_cyc, 1);
    chk("end_busy", 32'(busy), 0);
    chk("cycle_count", cycle_count, cfg ? 0 : n + LAT);
    chk("aborted", 32'(aborted), 32'(killed));
    chk("cfg_err", 32'(cfg_err), 32'(cfg));
    chk("reads", rd_seen, n);
    chk("writes", wr_seen, n);
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
  endtask

  task automatic chk_all_zero();
    chk("z_r_en", 32'(ram.r_en), 0);
    chk("z_r_addr", 32'(ram.r_addr), 0);
    chk("z_we", 32'(ram.we), 0);
    chk("z_w_addr", 32'(ram.w_addr), 0);
    chk("z_busy", 32'(busy), 0);
    chk("z_done", 32'(done), 0);
    chk("z_aborted", 32'(aborted), 0);
    chk("z_cfg_err", 32'(cfg_err), 0);
    chk("z_cycle_count", cycle_count, 0);
  endtask

  initial begin
    int w;
    resetn = 1'b0; pll_lock = 1'b1; start = 1'b0; abort = 1'b0;
    first_addr = '0; last_addr = '0; iterations = '0;
    #3;
    chk_all_zero();
    @(negedge clk);
    resetn = 1'b1;

    run_case(8'h10, 8'h13, 16'd1, 0, 1'b0);
    run_case(8'h00, 8'h02, 16'd3, 0, 1'b0);
    run_case(8'hFF, 8'hFF, 16'd0, 0, 1'b0);
    run_case(8'h20, 8'h1F, 16'd1, 0, 1'b0);
    run_case(8'h00, 8'h09, 16'd1, 3, 1'b0);
    run_case(8'h00, 8'h09, 16'd1, 3, 1'b1);

    // Start while unlocked must leave the previous (aborted) result untouched.
    pll_lock = 1'b0;
    @(negedge clk);
    first_addr = 8'h00; last_addr = 8'h03; iterations = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("nolock_r_en", 32'(ram.r_en), 0);
    chk("nolock_busy", 32'(busy), 0);
    chk("nolock_done", 32'(done), 1);
    chk("nolock_aborted", 32'(aborted), 1);
    pll_lock = 1'b1;

    // Reset in the middle of DRAIN.
    for (int k = 0; k < 4; k++) begin
      exp_rd.push_back(8'(k));
      exp_wr.push_back(8'(k));
    end
    rd_seen = 0;
    wr_seen = 0;
    @(negedge clk);
    first_addr = 8'h00; last_addr = 8'h03; iterations = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (ram.r_en && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("drain_reached", 32'(ram.r_en), 0);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk_all_zero();
    chk("rst_reads", rd_seen, 4);
    chk("rst_rd_left", exp_rd.size(), 0);
    exp_wr.delete();
    rd_cyc.delete();
    @(negedge clk);
    resetn = 1'b1;
    run_case(8'h05, 8'h08, 16'd2, 0, 1'b0);

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_test_sequencer.md
# mult_test_sequencer

Single-clock sequencer that drives one multiplier test run over the operand/result RAMs. It issues a contiguous range of operand read addresses, optionally repeating the range, and emits the matching result-RAM write enable and address after a fixed pipeline latency. It reports busy/done status and a cycle count to the test control register file. It sits between the control registers and the RAM arithmetic ports, replacing hand-chained address delay stages for one clock domain.

## Interface
- ADDR_WIDTH, 8, RAM address width
- LATENCY, 4, cycles from operand read address to result write (RAM read + mux + multiplier + data delays); legal range 1..64
- ITER_WIDTH, 16, width of repeat count
- pll_clock  in  1  sole clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pll_lock  in  1  PLL locked; gates start, loss aborts a run
- start  in  1  single-cycle run request
- abort  in  1  single-cycle stop request
- first_addr  in  ADDR_WIDTH  first operand address (sampled at start)
- last_addr  in  ADDR_WIDTH  last operand address, inclusive (sampled at start)
- iterations  in  ITER_WIDTH  passes over range; 0 treated as 1 (sampled at start)
- r_en  out  1  operand read valid
- r_addr  out  ADDR_WIDTH  operand read address
- we  out  1  result RAM write enable
- w_addr  out  ADDR_WIDTH  result RAM write address
- busy  out  1  run in progress (ISSUE or DRAIN)
- done  out  1  run finished; held until next accepted start
- aborted  out  1  last run ended by abort or lock loss; held with done
- cfg_err  out  1  last start rejected because last_addr < first_addr
- cycle_count  out  32  cycles spent in ISSUE+DRAIN of the last run

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Reset -> IDLE; all outputs 0, pipeline cleared.
- start accepted only in IDLE or DONE with pll_lock=1; otherwise ignored. Accept clears done/aborted/cfg_err/cycle_count and latches first/last/iterations.
- Accept with last_addr < first_addr: cfg_err=1, go directly to DONE, no reads issued.
- ISSUE: r_en=1 each cycle; r_addr starts at first_addr, +1 per cycle. At last_addr with passes remaining >1: next r_addr=first_addr, no bubble. Final last_addr issued -> DRAIN.
- DRAIN: r_en=0; stays exactly LATENCY cycles so every issued read produces its write; then DONE, done=1.
- we/w_addr = r_en/r_addr delayed exactly LATENCY cycles through a valid+address pipeline; independent of state.
- abort (or pll_lock=0) in ISSUE: r_en=0 from next cycle, aborted=1, go to DRAIN; in-flight writes still complete. In DRAIN: sets aborted, drain continues. In IDLE/DONE: no effect.
- start during ISSUE/DRAIN ignored. start and abort same cycle in IDLE/DONE: start wins only if pll_lock=1; abort ignored.
- cycle_count increments each cycle in ISSUE or DRAIN, saturates at 2^32-1.
- Address arithmetic is ADDR_WIDTH modulo; range cannot wrap since last >= first.

## Timing
- start sampled edge N -> r_en=1, r_addr=first_addr, busy=1 after edge N+1.
- Reads for a run of P passes over R addresses: P*R consecutive cycles.
- First we: LATENCY cycles after first r_en. Last we coincides with final DRAIN cycle; done=1 and busy=0 on the following edge.
- Normal run total: cycle_count = P*R + LATENCY.
- Asynchronous reset mid-run: all outputs 0 immediately, pending writes discarded.

## Structure
- Shared package: state enum, LATENCY_MAX=64 constant.
- One sub-module: seq_addr_pipe (parameters ADDR_WIDTH, DEPTH), shift register of {valid, addr}, async-reset valid bits only; Quartus shift-register recognition disabled to keep it in flops.

## Test plan
- first=0x10, last=0x13, iterations=1, LATENCY=4: r_addr 0x10..0x13 on 4 consecutive cycles, we/w_addr same sequence 4 cycles later, done after 8-cycle run, cycle_count=8.
- first=0, last=2, iterations=3: r_addr 0,1,2,0,1,2,0,1,2 with no gaps, 9 writes, cycle_count=13.
- iterations=0, first=last=0xFF: exactly one read/write at 0xFF, cycle_count=5.
- first=0x20, last=0x1F: cfg_err=1, done=1 next cycle, r_en/we never assert.
- abort on 3rd ISSUE cycle of 0..9 range: exactly 3 reads (0,1,2), 3 writes, aborted=1, cycle_count=7; pll_lock drop at same point gives identical result; start with pll_lock=0 ignored.
- resetn pulsed during DRAIN: all outputs 0 at once; fresh start afterwards runs normally.
